dbg_dump_sequencer: RTL and testbench

//  Debug-unit controller that walks the pipeline-latch debug mux through every valid select code.
//  For each code it waits for the mux's registered output, captures the 32-bit word and streams it as bytes to the UART TX.
//  It sits between the debug command FSM (start/abort) and the UART transmitter.
//  It is the only driver of the mux select while the pipeline is halted for inspection.

---
 rtl/dbg_dump_pkg.sv | 16 +
 rtl/dbg_byte_serializer.sv | 43 ++++
 rtl/dbg_dump_sequencer.sv | 90 +++++++++
 tb/tb_dbg_dump_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dbg_dump_pkg.sv
// dbg_dump_pkg: state encoding, dump table and sizing shared by the debug dump sequencer
package dbg_dump_pkg;
    typedef enum logic [2:0] {IDLE, SEL, WAIT, SEND, DONE} dumpState_t;
    localparam int NUM_ENTRIES = 19;
    localparam int BYTES_PER_WORD = 4;
    localparam logic [6:0] DUMP_TABLE [NUM_ENTRIES] = '{
        7'h00, 7'h01,
        7'h10, 7'h11, 7'h12, 7'h13, 7'h14, 7'h15,
        7'h20, 7'h21, 7'h23, 7'h24, 7'h25,
        7'h30, 7'h31, 7'h32, 7'h33,
        7'h40, 7'h41
    };
    function automatic logic [6:0] tableSel(input logic [4:0] idx);
        return (int'(idx) < NUM_ENTRIES) ? DUMP_TABLE[idx] : 7'h00;
    endfunction
endpackage

// File: rtl/dbg_byte_serializer.sv
// dbg_byte_serializer: shifts an optional tag byte then a 32-bit word out over valid/ready
module dbg_byte_serializer
    import dbg_dump_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic        tagEn,
    input  logic [7:0]  tag,
    input  logic [31:0] word,
    input  logic        txReady,
    output logic [7:0]  txData,
    output logic        txValid,
    output logic        lastAccepted
);
    logic [39:0] shiftReg;
    logic [2:0]  remaining;
    logic [31:0] ordered;
    logic        accept;
    assign ordered = MSB_FIRST ? {word[7:0], word[15:8], word[23:16], word[31:24]} : word;
    assign accept = txValid && txReady;
    assign lastAccepted = accept && remaining == 3'd1;
    assign txData = shiftReg[7:0];
    // The byte on the wire is always the low byte, so it cannot move until accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            shiftReg  <= '0;
            remaining <= '0;
            txValid   <= 1'b0;
        end else if (load) begin
            shiftReg  <= tagEn ? {ordered, tag} : {8'h00, ordered};
            remaining <= tagEn ? 3'(BYTES_PER_WORD + 1) : 3'(BYTES_PER_WORD);
            txValid   <= 1'b1;
        end else if (accept) begin
            shiftReg  <= shiftReg >> 8;
            remaining <= remaining - 3'd1;
            txValid   <= remaining != 3'd1;
        end
    end
endmodule

// File: rtl/dbg_dump_sequencer.sv
// dbg_dump_sequencer: walks the debug mux through the dump table and streams each word to the UART.
// Define DBG_DUMP_TAG_EN to prefix every entry with a {1'b0, mux_sel} tag byte.
module dbg_dump_sequencer
    import dbg_dump_pkg::*;
#(
    parameter int MUX_LAT   = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [6:0]  mux_sel,
    input  logic [31:0] mux_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic [4:0]  entry_idx
);
    localparam logic [4:0] LAST_IDX = 5'(NUM_ENTRIES - 1);
    dumpState_t state, nextState;
    logic [7:0] waitCnt;
    logic       load, lastAccepted, abortNow, tagEn;
`ifdef DBG_DUMP_TAG_EN
    assign tagEn = 1'b1;
`else
    assign tagEn = 1'b0;
`endif
    assign abortNow = abort && busy;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= nextState;
    end
    always_comb begin
        nextState = state;
        if (abortNow)
            nextState = IDLE;
        else
            case (state)
                IDLE:    nextState = (start && !abort) ? SEL : IDLE;
                SEL:     nextState = WAIT;
                WAIT:    nextState = (waitCnt == 8'd0) ? SEND : WAIT;
                SEND:    nextState = !lastAccepted ? SEND : (entry_idx == LAST_IDX) ? DONE : SEL;
                DONE:    nextState = IDLE;
                default: nextState = IDLE;
            endcase
    end
    always_comb begin
        busy = state == SEL || state == WAIT || state == SEND;
        done = state == DONE;
        load = state == WAIT && waitCnt == 8'd0;
    end
    // mux_sel only moves between entries, so it stays put for the whole SEL..SEND span
    always_ff @(posedge clk or posedge rst) begin
        if (rst || abortNow) begin
            mux_sel   <= 7'h00;
            entry_idx <= 5'd0;
            waitCnt   <= 8'd0;
        end else begin
            if (state == IDLE && nextState == SEL) begin
                mux_sel   <= tableSel(5'd0);
                entry_idx <= 5'd0;
            end else if (state == SEND && nextState == SEL) begin
                mux_sel   <= tableSel(entry_idx + 5'd1);
                entry_idx <= entry_idx + 5'd1;
            end
            if (state == SEL)
                waitCnt <= 8'(MUX_LAT - 1);
            else if (state == WAIT && waitCnt != 8'd0)
                waitCnt <= waitCnt - 8'd1;
        end
    end
    dbg_byte_serializer #(.MSB_FIRST(MSB_FIRST)) serializer (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .clear        (abortNow),
        .tagEn        (tagEn),
        .tag          ({1'b0, mux_sel}),
        .word         (mux_data),
        .txReady      (tx_ready),
        .txData       (tx_data),
        .txValid      (tx_valid),
        .lastAccepted (lastAccepted)
    );
endmodule

// File: tb/tb_dbg_dump_sequencer.sv
// tb_dbg_dump_sequencer: table-driven and randomized-backpressure checks of the debug dump sequencer
module tb_dbg_dump_sequencer;
`ifdef DBG_DUMP_TAG_EN
    localparam int BPE = 5;
`else
    localparam int BPE = 4;
`endif
    localparam int N = 19;
    localparam int EXP_DONE_EDGE = N * (2 + BPE) + 1;
    typedef struct {
        int    mode;
        int    restartIdx;
        bit    timed;
        string name;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst, start, abort, tx_ready;
    logic [6:0]  mux_sel;
    logic [31:0] mux_data = '0;
    logic [7:0]  tx_data;
    logic        tx_valid, busy, done;
    logic [4:0]  entry_idx;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  expStream[$];
    int          codes[N] = '{'h00, 'h01, 'h10, 'h11, 'h12, 'h13, 'h14, 'h15, 'h20, 'h21,
                              'h23, 'h24, 'h25, 'h30, 'h31, 'h32, 'h33, 'h40, 'h41};
    vec_t        vecs[5];

    dbg_dump_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mux_sel(mux_sel),
        .mux_data(mux_data), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done), .entry_idx(entry_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) mux_data <= {25'h0, mux_sel};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, " mux_sel"}, int'(mux_sel), 0);
        check({tag, " tx_data"}, int'(tx_data), 0);
        check({tag, " tx_valid"}, int'(tx_valid), 0);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " done"}, int'(done), 0);
        check({tag, " entry_idx"}, int'(entry_idx), 0);
    endtask

    task automatic runDump(input vec_t v);
        logic [7:0] got[$];
        int   doneCnt = 0, doneEdge = -1, stab = 0, busyAtDone = 0, k = 0, firstBad = -1;
        logic stall = 1'b0;
        logic [7:0] held = '0;
        bit   restarted = 1'b0;
        @(negedge clk);
        start = 1'b1; abort = 1'b0; tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (k < 3000 && !(doneCnt > 0 && k > doneEdge + 5)) begin
            if (stall && (!tx_valid || tx_data !== held)) stab++;
            if (done) begin
                doneCnt++;
                doneEdge = k + 1;
                if (busy) busyAtDone++;
            end
            tx_ready = (v.mode == 0) ? 1'b1 : (v.mode == 1) ? (k % 4 == 3) : 1'($urandom_range(0, 1));
            start = v.restartIdx >= 0 && !restarted && busy && int'(entry_idx) == v.restartIdx;
            if (start) restarted = 1'b1;
            if (tx_valid && tx_ready) got.push_back(tx_data);
            stall = tx_valid && !tx_ready;
            held = tx_data;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        for (int i = 0; i < got.size() && i < expStream.size(); i++)
            if (got[i] !== expStream[i] && firstBad < 0) firstBad = i;
        check({v.name, " byte_count"}, got.size(), expStream.size());
        check({v.name, " first_bad_byte_idx"}, firstBad, -1);
        check({v.name, " done_pulses"}, doneCnt, 1);
        check({v.name, " held_while_stalled_violations"}, stab, 0);
        check({v.name, " busy_during_done"}, busyAtDone, 0);
        check({v.name, " busy_after"}, int'(busy), 0);
        if (v.timed) check({v.name, " done_edge"}, doneEdge, EXP_DONE_EDGE);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, k, doneHits;
        logic prevGap;
        foreach (codes[i]) begin
            if (BPE == 5) expStream.push_back(8'(codes[i]));
            expStream.push_back(8'(codes[i]));
            repeat (3) expStream.push_back(8'h00);
        end
        vecs[0] = '{0, -1, 1'b1, "full"};
        vecs[1] = '{1, -1, 1'b0, "backpressure"};
        vecs[2] = '{0, 5, 1'b1, "restart_at_5"};
        vecs[3] = '{2, -1, 1'b0, "random_ready"};
        vecs[4] = '{2, 9, 1'b0, "random_ready_restart"};

        rst = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;

        foreach (vecs[i]) runDump(vecs[i]);

        // start together with abort from idle is ignored
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_with_abort busy", int'(busy), 0);

        // abort while the 2nd byte of entry 7 is offered
        @(negedge clk);
        start = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; k = 0;
        while (k < 1000 && !(entry_idx == 5'd7 && tx_valid && n == 7 * BPE + 1)) begin
            if (tx_valid && tx_ready) n++;
            @(negedge clk);
            k++;
        end
        check("abort_reached_target", int'(k < 1000), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort tx_valid", int'(tx_valid), 0);
        check("abort busy", int'(busy), 0);
        check("abort mux_sel", int'(mux_sel), 0);
        check("abort entry_idx", int'(entry_idx), 0);
        doneHits = 0;
        repeat (20) begin
            if (done || tx_valid) doneHits++;
            @(negedge clk);
        end
        check("abort quiet_after", doneHits, 0);
        runDump('{0, -1, 1'b1, "after_abort"});

        // reset while waiting on the mux of entry 3
        @(negedge clk);
        start = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        prevGap = 1'b0; k = 0;
        while (k < 1000 && !(prevGap && busy && !tx_valid && entry_idx == 5'd3)) begin
            prevGap = busy && !tx_valid;
            @(negedge clk);
            k++;
        end
        check("rst_reached_wait", int'(k < 1000), 1);
        rst = 1'b1;
        #1;
        checkResetOutputs("rst_mid_wait");
        @(negedge clk);
        rst = 1'b0;
        runDump('{3, -1, 1'b0, "after_reset"});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end
endmodule
